// File: rtl/mips_uart_tx_fifo.sv
// Buffered UART transmitter: store data is queued in a circular FIFO and sent back-to-back.
// Start bit leaves one cycle after the push into an idle block; writes to a full FIFO are dropped and flagged.
module mips_uart_tx_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int UART_Nbit  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int baudrate   = 9600,
  parameter int clk_freq   = 50000000,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic                          clr_tx_flag,
  output logic                          SerialDataOut,
  output logic                          Tx_flag,
  output logic                          tx_busy,
  output logic                          fifo_full,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          tx_overflow
);

  localparam int BAUD_DIV = clk_freq / baudrate;
  localparam int CW       = $clog2(BAUD_DIV);
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [PW:0]   FULL_CNT  = (PW + 1)'(FIFO_DEPTH);
  localparam logic [3:0]    NBIT_LAST = 4'(UART_Nbit - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_state;
  logic [UART_Nbit-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [PW:0]          r_count;
  logic [CW-1:0]        r_baud;
  logic [3:0]           r_bit_idx;
  logic [UART_Nbit-1:0] r_shift;
  logic                 r_parity, r_line, r_tx_flag, r_overflow;

  logic                 w_full, w_empty, w_push, w_pop, w_baud_end, w_frame_end;
  logic [UART_Nbit-1:0] w_head;

  assign w_full      = (r_count == FULL_CNT);
  assign w_empty     = (r_count == '0);
  assign w_push      = wr_en & ~w_full;
  assign w_baud_end  = (r_baud == BAUD_LAST);
  assign w_frame_end = (r_state == S_STOP) & w_baud_end & (r_bit_idx == STOP_LAST);
  // Pop either from idle or at the very end of a stop bit, so queued frames have no idle gap.
  assign w_pop       = ~w_empty & ((r_state == S_IDLE) | w_frame_end);
  assign w_head      = r_mem[r_rd_ptr];

  generate
    if (DATA_WIDTH > UART_Nbit) begin : g_hi
      logic w_unused_hi;
      assign w_unused_hi = ^wr_data[DATA_WIDTH-1:UART_Nbit];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data[UART_Nbit-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_parity   <= 1'b0;
      r_line     <= 1'b1;
      r_tx_flag  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase

      // A new overflow beats a simultaneous clear; for Tx_flag the clear wins.
      if (wr_en & w_full)   r_overflow <= 1'b1;
      else if (clr_tx_flag) r_overflow <= 1'b0;
      if (clr_tx_flag | w_push)      r_tx_flag <= 1'b0;
      else if (w_frame_end & w_empty) r_tx_flag <= 1'b1;

      if (r_state != S_IDLE) r_baud <= w_baud_end ? '0 : r_baud + 1'b1;

      case (r_state)
        S_IDLE: begin
          r_line <= 1'b1;
          if (w_pop) begin
            r_shift  <= w_head;
            r_parity <= (^w_head) ^ (PARITY_ODD != 0);
            r_baud   <= '0;
            r_line   <= 1'b0;
            r_state  <= S_START;
          end
        end
        S_START: if (w_baud_end) begin
          r_state   <= S_DATA;
          r_bit_idx <= '0;
          r_line    <= r_shift[0];
        end
        S_DATA: if (w_baud_end) begin
          if (r_bit_idx == NBIT_LAST) begin
            r_bit_idx <= '0;
            if (PARITY_EN != 0) begin
              r_state <= S_PARITY;
              r_line  <= r_parity;
            end else begin
              r_state <= S_STOP;
              r_line  <= 1'b1;
            end
          end else begin
            r_bit_idx <= r_bit_idx + 1'b1;
            r_shift   <= r_shift >> 1;
            r_line    <= r_shift[1];
          end
        end
        S_PARITY: if (w_baud_end) begin
          r_state   <= S_STOP;
          r_bit_idx <= '0;
          r_line    <= 1'b1;
        end
        S_STOP: if (w_baud_end) begin
          if (r_bit_idx == STOP_LAST) begin
            if (w_pop) begin
              r_shift  <= w_head;
              r_parity <= (^w_head) ^ (PARITY_ODD != 0);
              r_line   <= 1'b0;
              r_state  <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_bit_idx <= r_bit_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign SerialDataOut = r_line;
  assign Tx_flag       = r_tx_flag;
  assign tx_overflow   = r_overflow;
  assign fifo_count    = r_count;
  assign fifo_full     = w_full;
  assign fifo_empty    = w_empty;
  assign tx_busy       = (r_state != S_IDLE) | ~w_empty;

endmodule

// File: tb/tb_mips_uart_tx_fifo.sv
// Directed bench: plain framing, back-to-back frames, overflow, parity/two stop bits, reset abort, flag races.
module tb_mips_uart_tx_fifo;

  localparam int BAUD = 10;

  logic        clk = 1'b0;
  logic        reset, wr_en, clr;
  logic [31:0] wr_data;

  logic       a_line, a_tf, a_busy, a_full, a_empty, a_ovf;
  logic [2:0] a_count;
  logic       e_line, e_tf, e_busy, e_full, e_empty, e_ovf;
  logic [3:0] e_count;
  logic       o_line, o_tf, o_busy, o_full, o_empty, o_ovf;
  logic [3:0] o_count;

  int   n_chk  = 0;
  int   n_fail = 0;
  logic last_tf;

  always #5 clk = ~clk;

  mips_uart_tx_fifo #(.clk_freq(50), .baudrate(5), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .clr_tx_flag(clr),
    .SerialDataOut(a_line), .Tx_flag(a_tf), .tx_busy(a_busy), .fifo_full(a_full),
    .fifo_empty(a_empty), .fifo_count(a_count), .tx_overflow(a_ovf));

  mips_uart_tx_fifo #(.clk_freq(50), .baudrate(5), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_even (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .clr_tx_flag(clr),
    .SerialDataOut(e_line), .Tx_flag(e_tf), .tx_busy(e_busy), .fifo_full(e_full),
    .fifo_empty(e_empty), .fifo_count(e_count), .tx_overflow(e_ovf));

  mips_uart_tx_fifo #(.clk_freq(50), .baudrate(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_odd (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .clr_tx_flag(clr),
    .SerialDataOut(o_line), .Tx_flag(o_tf), .tx_busy(o_busy), .fifo_full(o_full),
    .fifo_empty(o_empty), .fifo_count(o_count), .tx_overflow(o_ovf));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic line_of(input int s);
    case (s)
      0:       return a_line;
      1:       return e_line;
      default: return o_line;
    endcase
  endfunction

  function automatic logic tf_of(input int s);
    case (s)
      0:       return a_tf;
      1:       return e_tf;
      default: return o_tf;
    endcase
  endfunction

  // Samples the line for n cycles and requires it to hold expb throughout.
  task automatic check_seg(input string tag, input int s, input logic expb, input int n);
    logic [31:0] v, e;
    v = '0;
    e = '0;
    for (int c = 0; c < n; c++) begin
      v[c] = line_of(s);
      e[c] = expb;
      if (c == n - 1) last_tf = tf_of(s);
      tick();
    end
    chk(tag, v, e);
  endtask

  task automatic check_frame(input string tag, input int s, input logic [7:0] b, input int first,
                             input bit par_en, input logic par_val, input int stop_cyc);
    check_seg({tag, ".start"}, s, 1'b0, BAUD - first);
    for (int i = 0; i < 8; i++) check_seg($sformatf("%s.d%0d", tag, i), s, b[i], BAUD);
    if (par_en) check_seg({tag, ".parity"}, s, par_val, BAUD);
    check_seg({tag, ".stop"}, s, 1'b1, stop_cyc);
  endtask

  task automatic push1(input logic [31:0] d);
    wr_data = d;
    wr_en   = 1'b1;
    tick();
    wr_en   = 1'b0;
  endtask

  logic [7:0] b3 [6];

  initial begin
    reset = 1'b1; wr_en = 1'b0; clr = 1'b0; wr_data = '0;
    b3 = '{8'h81, 8'h42, 8'h24, 8'h18, 8'hF0, 8'h0F};
    tick(); tick();
    reset = 1'b0;
    chk("rst.line",  32'(a_line),  1);
    chk("rst.tf",    32'(a_tf),    0);
    chk("rst.ovf",   32'(a_ovf),   0);
    chk("rst.busy",  32'(a_busy),  0);
    chk("rst.empty", 32'(a_empty), 1);
    chk("rst.full",  32'(a_full),  0);
    chk("rst.count", 32'(a_count), 0);

    // 1: single byte, 100-cycle frame
    push1(32'h0000_00A5);
    chk("t1.count_push", 32'(a_count), 1);
    chk("t1.busy",       32'(a_busy),  1);
    chk("t1.line_idle",  32'(a_line),  1);
    tick();
    check_frame("t1", 0, 8'hA5, 0, 1'b0, 1'b0, BAUD);
    chk("t1.tf_cycle99",  32'(last_tf), 0);
    chk("t1.tf_cycle100", 32'(a_tf),    1);
    chk("t1.count_end",   32'(a_count), 0);
    chk("t1.busy_end",    32'(a_busy),  0);

    // 2: three consecutive pushes, back-to-back frames
    wr_en = 1'b1;
    wr_data = 32'h11; tick();
    wr_data = 32'h22; tick();
    wr_data = 32'h33; tick();
    wr_en = 1'b0;
    chk("t2.count_peak", 32'(a_count), 2);
    chk("t2.tf_cleared", 32'(a_tf),    0);
    check_frame("t2a", 0, 8'h11, 1, 1'b0, 1'b0, BAUD);
    chk("t2a.tf", 32'(last_tf), 0);
    check_frame("t2b", 0, 8'h22, 0, 1'b0, 1'b0, BAUD);
    chk("t2b.tf", 32'(last_tf), 0);
    check_frame("t2c", 0, 8'h33, 0, 1'b0, 1'b0, BAUD);
    chk("t2c.tf_before", 32'(last_tf), 0);
    chk("t2c.tf_after",  32'(a_tf),    1);

    // 3: six pushes into a depth-4 FIFO while the first byte is on the line
    for (int i = 0; i < 6; i++) begin
      wr_data = {24'hABCDEF, b3[i]};
      wr_en   = 1'b1;
      tick();
    end
    wr_en = 1'b0;
    chk("t3.count", 32'(a_count), 4);
    chk("t3.full",  32'(a_full),  1);
    chk("t3.empty", 32'(a_empty), 0);
    chk("t3.ovf",   32'(a_ovf),   1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("t3.ovf_clr",   32'(a_ovf),   0);
    chk("t3.count_clr", 32'(a_count), 4);
    check_frame("t3.b1", 0, b3[0], 5, 1'b0, 1'b0, BAUD);
    for (int i = 1; i < 5; i++)
      check_frame($sformatf("t3.b%0d", i + 1), 0, b3[i], 0, 1'b0, 1'b0, BAUD);
    chk("t3.tf",        32'(a_tf),    1);
    chk("t3.count_end", 32'(a_count), 0);
    check_seg("t3.no_sixth", 0, 1'b1, 30);

    // 4: even then odd parity, two stop bits
    reset = 1'b1; tick(); reset = 1'b0;
    push1(32'h07);
    tick();
    check_frame("t4e", 1, 8'h07, 0, 1'b1, 1'b1, 2 * BAUD);
    chk("t4e.tf_cycle119", 32'(last_tf), 0);
    chk("t4e.tf_cycle120", 32'(e_tf),    1);
    reset = 1'b1; tick(); reset = 1'b0;
    push1(32'h07);
    tick();
    check_frame("t4o", 2, 8'h07, 0, 1'b1, 1'b0, 2 * BAUD);
    chk("t4o.tf_cycle119", 32'(last_tf), 0);
    chk("t4o.tf_cycle120", 32'(o_tf),    1);

    // 5: reset during data bit 3 with two bytes queued
    reset = 1'b1; tick(); reset = 1'b0;
    wr_en = 1'b1;
    wr_data = 32'hF7; tick();
    wr_data = 32'h55; tick();
    wr_data = 32'hAA; tick();
    wr_en = 1'b0;
    repeat (43) tick();
    chk("t5.line_bit3",    32'(a_line),  0);
    chk("t5.count_before", 32'(a_count), 2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5.line",  32'(a_line),  1);
    chk("t5.busy",  32'(a_busy),  0);
    chk("t5.empty", 32'(a_empty), 1);
    chk("t5.tf",    32'(a_tf),    0);
    chk("t5.count", 32'(a_count), 0);
    for (int i = 0; i < 5; i++) check_seg($sformatf("t5.quiet%0d", i), 0, 1'b1, 30);

    // 6: clear and write in the same cycle while Tx_flag is set
    push1(32'h5A);
    tick();
    check_frame("t6a", 0, 8'h5A, 0, 1'b0, 1'b0, BAUD);
    chk("t6a.tf", 32'(a_tf), 1);
    clr = 1'b1; wr_en = 1'b1; wr_data = 32'hC3;
    tick();
    clr = 1'b0; wr_en = 1'b0;
    chk("t6.tf_cleared", 32'(a_tf),    0);
    chk("t6.accepted",   32'(a_count), 1);
    tick();
    check_frame("t6b", 0, 8'hC3, 0, 1'b0, 1'b0, BAUD);
    chk("t6b.tf", 32'(a_tf), 1);

    // 7: write landing on the final stop-bit edge: clear beats set, one idle cycle follows
    push1(32'h3C);
    tick();
    check_frame("t7a", 0, 8'h3C, 0, 1'b0, 1'b0, BAUD - 1);
    chk("t7a.last_stop", 32'(a_line), 1);
    push1(32'h66);
    chk("t7.tf_clear_wins", 32'(a_tf),    0);
    chk("t7.count",         32'(a_count), 1);
    chk("t7.line_gap",      32'(a_line),  1);
    tick();
    check_frame("t7b", 0, 8'h66, 0, 1'b0, 1'b0, BAUD);
    chk("t7b.tf", 32'(a_tf), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
